lane_serdes_converter: RTL and testbench

//   Multi-lane parallel<->serial converter for the bin-tree interconnect leaf ports.

---
 rtl/lane_serdes_converter.sv | 174 +++++++++++++++++
 tb/tb_lane_serdes_converter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_serdes_converter.sv
// Multi-lane parallel<->serial word converter with parallel load, S2P and P2S modes; optional parity beat (macro LANE_SERDES_PARITY_EN).
// Latency: LOAD done 2 cycles after start; P2S beats start 1 cycle after start, done after the last beat; S2P done 1 cycle after the last accepted beat.
// Backpressure: serial_valid low stalls S2P indefinitely; P2S has no stall; start is ignored while busy; abort cancels without done.
module lane_serdes_converter #(
    parameter int LANES    = 4,
    parameter int WORD_LEN = 32,
    parameter int LANE_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic                       abort,
    input  logic [LANES*LANE_W-1:0]    serial_in,
    input  logic                       serial_valid,
    input  logic [LANES*WORD_LEN-1:0]  parallel_in,
    output logic [LANES*LANE_W-1:0]    serial_out,
    output logic                       serial_out_valid,
    output logic [LANES*WORD_LEN-1:0]  parallel_out,
    output logic                       busy,
    output logic                       done,
    output logic [LANES-1:0]           parity_err
);

    localparam int BEATS = WORD_LEN / LANE_W;
`ifdef LANE_SERDES_PARITY_EN
    localparam int XFER_BEATS = BEATS + 1;
`else
    localparam int XFER_BEATS = BEATS;
`endif
    localparam int CNT_W = $clog2(BEATS + 2);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(XFER_BEATS - 1);
    localparam logic [CNT_W-1:0] DATA_BEATS = CNT_W'(BEATS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_OUT,
        ST_SHIFT_IN,
        ST_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [LANES*WORD_LEN-1:0]   word_q, word_d;
    logic                        start_ok;

    // A start counts only from IDLE/DONE and only with a real mode.
    assign start_ok = start && (mode != 2'd0) &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state, beat counter and word register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    cnt_d = '0;
                    case (mode)
                        2'd1:    state_d = ST_SHIFT_IN;
                        2'd2:    state_d = ST_LOAD;
                        default: state_d = ST_SHIFT_OUT;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    word_d  = parallel_in;
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT_OUT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT_IN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (serial_valid) begin
                    // The parity beat (cnt == BEATS) is checked, never stored.
                    if (cnt_q < DATA_BEATS) begin
                        for (int k = 0; k < LANES; k++) begin
                            word_d[k*WORD_LEN + int'(cnt_q)*LANE_W +: LANE_W] =
                                serial_in[k*LANE_W +: LANE_W];
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and word register; reset discards any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // P2S beat data, driven from the word register only while shifting out.
    always_comb begin
        serial_out       = '0;
        serial_out_valid = 1'b0;
        if (state_q == ST_SHIFT_OUT) begin
            serial_out_valid = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                if (cnt_q < DATA_BEATS) begin
                    serial_out[k*LANE_W +: LANE_W] =
                        word_q[k*WORD_LEN + int'(cnt_q)*LANE_W +: LANE_W];
                end else begin
                    serial_out[k*LANE_W] = ^word_q[k*WORD_LEN +: WORD_LEN];
                end
            end
        end
    end

    assign busy         = (state_q == ST_LOAD) || (state_q == ST_SHIFT_OUT) ||
                          (state_q == ST_SHIFT_IN);
    assign done         = (state_q == ST_DONE);
    assign parallel_out = word_q;

`ifdef LANE_SERDES_PARITY_EN
    logic [LANES-1:0] parity_err_q, parity_err_d;

    // Parity flags: cleared on start, captured when the S2P parity beat is accepted.
    always_comb begin
        parity_err_d = parity_err_q;
        if (start_ok) begin
            parity_err_d = '0;
        end else if ((state_q == ST_SHIFT_IN) && !abort && serial_valid &&
                     (cnt_q == DATA_BEATS)) begin
            for (int k = 0; k < LANES; k++) begin
                parity_err_d[k] = serial_in[k*LANE_W] ^ (^word_q[k*WORD_LEN +: WORD_LEN]);
            end
        end
    end

    // Parity flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_q <= '0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = '0;
`endif

endmodule

// File: tb/tb_lane_serdes_converter.sv
module tb_lane_serdes_converter;

    localparam int LANES = 4;
    localparam int WL    = 32;
    localparam int LW    = 2;
    localparam int BEATS = WL / LW;
`ifdef LANE_SERDES_PARITY_EN
    localparam int XB = BEATS + 1;
`else
    localparam int XB = BEATS;
`endif

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic [1:0]              mode;
    logic                    abort;
    logic [LANES*LW-1:0]     serial_in;
    logic                    serial_valid;
    logic [LANES*WL-1:0]     parallel_in;
    logic [LANES*LW-1:0]     serial_out;
    logic                    serial_out_valid;
    logic [LANES*WL-1:0]     parallel_out;
    logic                    busy;
    logic                    done;
    logic [LANES-1:0]        parity_err;

    lane_serdes_converter #(.LANES(LANES), .WORD_LEN(WL), .LANE_W(LW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .mode             (mode),
        .abort            (abort),
        .serial_in        (serial_in),
        .serial_valid     (serial_valid),
        .parallel_in      (parallel_in),
        .serial_out       (serial_out),
        .serial_out_valid (serial_out_valid),
        .parallel_out     (parallel_out),
        .busy             (busy),
        .done             (done),
        .parity_err       (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one plain word per lane.
    logic [WL-1:0] mw [LANES];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*WL-1:0] model_par();
        logic [LANES*WL-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*WL +: WL] = mw[k];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [LANES*WL-1:0] d);
        start = 1'b1; mode = 2'd2; parallel_in = d;
        step();
        start = 1'b0; mode = 2'($urandom);
        check("load_busy", busy, 1);
        check("load_done_early", done, 0);
        step();
        for (int k = 0; k < LANES; k++) mw[k] = d[k*WL +: WL];
        check("load_done", done, 1);
        check("load_par", parallel_out, model_par());
    endtask

    task automatic do_p2s(input bit extra_starts);
        logic [LANES*LW-1:0] e;
        start = 1'b1; mode = 2'd3;
        step();
        for (int b = 0; b < XB; b++) begin
            if (extra_starts && (b == 3 || b == 9)) begin
                start = 1'b1; mode = 2'($urandom_range(1, 3));
            end else begin
                start = 1'b0;
            end
            e = '0;
            for (int k = 0; k < LANES; k++) begin
                if (b < BEATS) e[k*LW +: LW] = LW'(mw[k] >> (b*LW));
                else           e[k*LW] = ^mw[k];
            end
            check("p2s_valid", serial_out_valid, 1);
            check("p2s_busy", busy, 1);
            check("p2s_done_early", done, 0);
            check($sformatf("p2s_beat%0d", b), serial_out, e);
            step();
        end
        start = 1'b0;
        check("p2s_done", done, 1);
        check("p2s_valid_off", serial_out_valid, 0);
        check("p2s_out_zero", serial_out, 0);
        check("p2s_reg_kept", parallel_out, model_par());
        step();
        check("p2s_single_done", done, 0);
        check("p2s_idle", busy, 0);
    endtask

    // stall_mode: 0 never stall, 1 toggle, 2 random. abort_at/bad_lane < 0 disables.
    task automatic do_s2p(input int stall_mode, input int abort_at, input int bad_lane, input bit fix_l1);
        logic [WL-1:0]        nw [LANES];
        logic [LANES*LW-1:0]  si;
        logic [LANES-1:0]     exp_pe;
        int acc, cyc;
        bit fin, v, ab;
        for (int k = 0; k < LANES; k++) nw[k] = $urandom;
        if (fix_l1) nw[1] = 32'h12345678;
        start = 1'b1; mode = 2'd1;
        step();
        start = 1'b0; mode = 2'($urandom);
        check("s2p_pe_cleared", parity_err, 0);
        acc = 0; cyc = 0; fin = 0;
        while (!fin && cyc < 400) begin
            if (stall_mode == 0)      v = 1'b1;
            else if (stall_mode == 1) v = (cyc % 2) == 1;
            else                      v = 1'($urandom_range(0, 1));
            si = LANES*LW'($urandom);
            if (v) begin
                si = '0;
                for (int k = 0; k < LANES; k++) begin
                    if (acc < BEATS) si[k*LW +: LW] = nw[k][acc*LW +: LW];
                    else             si[k*LW] = (^nw[k]) ^ (k == bad_lane);
                end
            end
            ab = v && (acc == abort_at);
            serial_valid = v; serial_in = si; abort = ab;
            step();
            cyc++;
            abort = 1'b0;
            if (ab) begin
                serial_valid = 1'b0;
                check("abort_idle", busy, 0);
                check("abort_no_done", done, 0);
                check("abort_partial", parallel_out, model_par());
                step();
                check("abort_no_done_late", done, 0);
                fin = 1;
            end else begin
                if (v) begin
                    if (acc < BEATS)
                        for (int k = 0; k < LANES; k++) mw[k][acc*LW +: LW] = nw[k][acc*LW +: LW];
                    acc++;
                end
                check("s2p_par", parallel_out, model_par());
                if (acc == XB) begin
                    fin = 1;
                    check("s2p_done", done, 1);
                    check("s2p_busy_off", busy, 0);
                    exp_pe = '0;
`ifdef LANE_SERDES_PARITY_EN
                    if (bad_lane >= 0) exp_pe[bad_lane] = 1'b1;
`endif
                    check("s2p_parity_err", parity_err, exp_pe);
                    if (fix_l1) check("s2p_lane1", parallel_out[63:32], 32'h12345678);
                end else begin
                    check("s2p_done_early", done, 0);
                    check("s2p_busy", busy, 1);
                end
            end
        end
        serial_valid = 1'b0;
        if (!fin) check("s2p_timeout", 0, 1);
    endtask

    initial begin
        logic [LANES*WL-1:0] d;
        reset = 1'b0; start = 1'b0; mode = 2'd0; abort = 1'b0;
        serial_in = '0; serial_valid = 1'b0; parallel_in = '0;
        for (int k = 0; k < LANES; k++) mw[k] = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", serial_out_valid, 0);
        check("rst_sout", serial_out, 0);
        check("rst_par", parallel_out, 0);
        check("rst_pe", parity_err, 0);
        #10 reset = 1'b1;
        step();

        // mode 0 and abort outside busy are no-ops
        start = 1'b1; mode = 2'd0; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("mode0_busy", busy, 0);
        check("mode0_done", done, 0);

        // load then back-to-back P2S
        d = {LANES*WL/32{32'($urandom)}};
        d[31:0] = 32'hDEADBEEF;
        do_load(d);
        do_p2s(1'b0);

        // S2P with toggling valid, lane1 fixed
        do_s2p(1, -1, -1, 1'b1);
        step();

        // starts during P2S ignored
        for (int k = 0; k < LANES; k++) d[k*WL +: WL] = $urandom;
        do_load(d);
        do_p2s(1'b1);

        // abort at beat 5
        do_s2p(1, 5, -1, 1'b0);

`ifdef LANE_SERDES_PARITY_EN
        do_s2p(1, -1, 2, 1'b0);
        step();
        do_s2p(2, -1, -1, 1'b0);
        step();
`endif

        // random mix
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    for (int k = 0; k < LANES; k++) d[k*WL +: WL] = $urandom;
                    do_load(d);
                    step();
                end
                1: do_p2s(1'($urandom_range(0, 1)));
                default: begin
                    do_s2p(2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS-1)) : -1,
                           -1, 1'b0);
                    step();
                end
            endcase
        end

        // reset in the middle of SHIFT_OUT, between edges
        start = 1'b1; mode = 2'd3;
        step();
        start = 1'b0;
        step(); step(); step();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < LANES; k++) mw[k] = '0;
        check("midrst_sout", serial_out, 0);
        check("midrst_valid", serial_out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_par", parallel_out, model_par());
        @(negedge clk);
        reset = 1'b1;
        step(); step();
        check("postrst_done", done, 0);
        check("postrst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
